// File: rtl/mem_server_if.sv
// mem_server_if
//   Bundles the core-facing memory ports and the host program-load port of
//   mem_server. clk/rst are not part of the bundle.
//
//   Core fetch : pc (addr in), instr (data out)
//   Core data  : readmem0 / in_mem0 (read), mem_wen / mem_waddr / mem_wval (write)
//   Host load  : ld_valid, ld_ready, ld_addr, ld_data, ld_last
//   Status     : core_run
//
//   Modports: slave = mem_server side, master = core/host side.
interface mem_server_if;
    logic [15:0] pc;
    logic [31:0] instr;
    logic [15:0] readmem0;
    logic [15:0] in_mem0;
    logic        mem_wen;
    logic [15:0] mem_waddr;
    logic [15:0] mem_wval;
    logic        ld_valid;
    logic        ld_ready;
    logic [15:0] ld_addr;
    logic [31:0] ld_data;
    logic        ld_last;
    logic        core_run;

    modport slave (
        input  pc, readmem0, mem_wen, mem_waddr, mem_wval,
        input  ld_valid, ld_addr, ld_data, ld_last,
        output instr, in_mem0, ld_ready, core_run
    );

    modport master (
        output pc, readmem0, mem_wen, mem_waddr, mem_wval,
        output ld_valid, ld_addr, ld_data, ld_last,
        input  instr, in_mem0, ld_ready, core_run
    );
endinterface

// File: rtl/mem_server.sv
// mem_server
//   Owns the instruction RAM (32-bit words) and data RAM (16-bit words) for
//   the processor core. After reset it sits in LOAD, taking the program from
//   the host over the ld_* handshake; once the ld_last word is accepted it
//   enters RUN and serves 1-cycle registered reads on the fetch and data
//   ports and commits data writes.
//
// Parameters
//   IMEM_DEPTH : instruction RAM depth (power of two, <= 65536)
//   DMEM_DEPTH : data RAM depth (power of two, <= 65536)
//
// Ports
//   clk       : clock, rising edge
//   rst       : synchronous active-high reset (RAM contents are kept)
//   bus       : mem_server_if.slave (fetch, data, load and core_run signals)
//   dbg_state : current FSM state, 0 = LOAD, 1 = RUN
//
// Build option
//   MEM_SERVER_BYPASS_EN : when defined, a RUN-state data write and read of
//   the same (wrapped) address at one edge returns the written value.
//   Otherwise the read returns the old RAM contents.
//
// Load handshake: a word transfers on every rising edge where
// ld_valid && ld_ready. ld_ready depends only on state and rst, never on
// ld_valid, so the host may hold ld_valid and stream one word per cycle.
module mem_server #(
    parameter int IMEM_DEPTH = 256,
    parameter int DMEM_DEPTH = 256
) (
    input  logic        clk,
    input  logic        rst,
    mem_server_if.slave bus,
    output logic        dbg_state
);
    localparam int IAW = $clog2(IMEM_DEPTH);
    localparam int DAW = $clog2(DMEM_DEPTH);

    typedef enum logic {
        LOAD = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t state;

    logic [31:0] imem [IMEM_DEPTH];
    logic [15:0] dmem [DMEM_DEPTH];

    logic [31:0] instr_q;
    logic [15:0] in_mem0_q;

    // Address wrap: only the low bits select a RAM word.
    logic [IAW-1:0] fetch_idx;
    logic [IAW-1:0] ld_idx;
    logic [DAW-1:0] rd_idx;
    logic [DAW-1:0] wr_idx;

    assign fetch_idx = bus.pc[IAW-1:0];
    assign ld_idx    = bus.ld_addr[IAW-1:0];
    assign rd_idx    = bus.readmem0[DAW-1:0];
    assign wr_idx    = bus.mem_waddr[DAW-1:0];

    // Upper address bits are intentionally discarded.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{bus.pc, bus.ld_addr, bus.readmem0, bus.mem_waddr};

    // ld_ready is low on the reset cycle itself so a beat presented then is
    // never counted as transferred by the host.
    logic ld_ready_w;
    logic ld_fire;
    logic dm_we;

    assign ld_ready_w = (state == LOAD) && !rst;
    assign ld_fire    = bus.ld_valid && ld_ready_w;
    assign dm_we      = (state == RUN) && bus.mem_wen && !rst;

    // Data read value for this edge, with optional write forwarding.
    logic [15:0] rd_data;
    always_comb begin
        rd_data = dmem[rd_idx];
`ifdef MEM_SERVER_BYPASS_EN
        if (dm_we && (wr_idx == rd_idx)) begin
            rd_data = bus.mem_wval;
        end
`endif
    end

    // RAM writes carry no reset so contents survive rst.
    always_ff @(posedge clk) begin
        if (ld_fire) begin
            imem[ld_idx] <= bus.ld_data;
        end
    end

    always_ff @(posedge clk) begin
        if (dm_we) begin
            dmem[wr_idx] <= bus.mem_wval;
        end
    end

    // Loader FSM with registered read outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= LOAD;
            instr_q   <= '0;
            in_mem0_q <= '0;
        end else begin
            // Data reads are served in both states so the host can inspect
            // data RAM while loading.
            in_mem0_q <= rd_data;
            case (state)
                LOAD: begin
                    instr_q <= '0;
                    if (ld_fire && bus.ld_last) begin
                        state <= RUN;
                    end
                end
                RUN: begin
                    instr_q <= imem[fetch_idx];
                end
                default: begin
                    state   <= LOAD;
                    instr_q <= '0;
                end
            endcase
        end
    end

    assign bus.instr    = instr_q;
    assign bus.in_mem0  = in_mem0_q;
    assign bus.ld_ready = ld_ready_w;
    assign bus.core_run = (state == RUN);
    assign dbg_state    = (state == RUN);
endmodule

// File: tb/tb_mem_server.sv
// tb_mem_server
//   Directed bench for mem_server. Each vector drives one cycle of inputs,
//   checks ld_ready before the edge and the registered outputs after it.
module tb_mem_server;
    logic clk;
    logic rst;
    logic dbg_state;

    mem_server_if bus ();

    mem_server #(
        .IMEM_DEPTH(256),
        .DMEM_DEPTH(256)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus.slave),
        .dbg_state(dbg_state)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: run did not finish within 100000 time units");
        $fatal(1, "watchdog");
    end

    // Vector record: inputs then expected outputs.
    typedef struct {
        logic        rst;
        logic [15:0] pc;
        logic [15:0] rd;
        logic        wen;
        logic [15:0] wa;
        logic [15:0] wv;
        logic        ldv;
        logic [15:0] la;
        logic [31:0] ld;
        logic        ll;
        logic        e_ready;
        logic        e_run;
        logic [31:0] e_instr;
        logic        ck_dm;
        logic [15:0] e_dm;
    } vec_t;

    function automatic vec_t mk(
        input logic rst_i, input logic [15:0] pc_i, input logic [15:0] rd_i,
        input logic wen_i, input logic [15:0] wa_i, input logic [15:0] wv_i,
        input logic ldv_i, input logic [15:0] la_i, input logic [31:0] ld_i,
        input logic ll_i, input logic er_i, input logic eu_i,
        input logic [31:0] ei_i, input logic cd_i, input logic [15:0] ed_i);
        vec_t v;
        v.rst = rst_i;  v.pc = pc_i;  v.rd = rd_i;
        v.wen = wen_i;  v.wa = wa_i;  v.wv = wv_i;
        v.ldv = ldv_i;  v.la = la_i;  v.ld = ld_i;  v.ll = ll_i;
        v.e_ready = er_i;  v.e_run = eu_i;  v.e_instr = ei_i;
        v.ck_dm = cd_i;  v.e_dm = ed_i;
        return v;
    endfunction

`ifdef MEM_SERVER_BYPASS_EN
    localparam logic [15:0] COL_EXP = 16'h5555;
`else
    localparam logic [15:0] COL_EXP = 16'hAAAA;
`endif

    // Scoreboard counters
    int n_vec;
    int n_err;
    int n_chk;
    int cur_vec;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL vec %0d %s: got %h expected %h", cur_vec, name, act, exp);
        end
    endtask

    // Driver: inputs at negedge, ld_ready checked before the edge, registered
    // outputs checked 1 unit after the edge.
    task automatic apply(input vec_t v);
        @(negedge clk);
        rst           = v.rst;
        bus.pc        = v.pc;
        bus.readmem0  = v.rd;
        bus.mem_wen   = v.wen;
        bus.mem_waddr = v.wa;
        bus.mem_wval  = v.wv;
        bus.ld_valid  = v.ldv;
        bus.ld_addr   = v.la;
        bus.ld_data   = v.ld;
        bus.ld_last   = v.ll;
        #1;
        check("ld_ready", {31'd0, bus.ld_ready}, {31'd0, v.e_ready});
        @(posedge clk);
        #1;
        check("core_run", {31'd0, bus.core_run}, {31'd0, v.e_run});
        check("dbg_state", {31'd0, dbg_state}, {31'd0, v.e_run});
        check("instr", bus.instr, v.e_instr);
        if (v.ck_dm) begin
            check("in_mem0", {16'd0, bus.in_mem0}, {16'd0, v.e_dm});
        end
        n_vec++;
        cur_vec++;
    endtask

    vec_t tbl [27];

    initial begin
        logic [15:0] a;
        logic [31:0] d;
        n_vec = 0; n_err = 0; n_chk = 0; cur_vec = 0;
        rst = 1'b1;
        bus.pc = '0; bus.readmem0 = '0; bus.mem_wen = 1'b0;
        bus.mem_waddr = '0; bus.mem_wval = '0;
        bus.ld_valid = 1'b0; bus.ld_addr = '0; bus.ld_data = '0; bus.ld_last = 1'b0;

        //             rst pc        rd        wen wa        wv        ldv la     ld            ll  rdy run instr         ckd dm
        // load then fetch
        tbl[0]  = mk(1, 16'h0000, 16'h0000, 0, 16'h0000, 16'h0000, 0, 16'h0, 32'h0,        0,  0, 0, 32'h0,        1, 16'h0000);
        tbl[1]  = mk(0, 16'h0000, 16'h0000, 0, 16'h0000, 16'h0000, 1, 16'h0, 32'h11111111, 0,  1, 0, 32'h0,        0, 16'h0000);
        tbl[2]  = mk(0, 16'h0000, 16'h0000, 0, 16'h0000, 16'h0000, 1, 16'h1, 32'h22222222, 0,  1, 0, 32'h0,        0, 16'h0000);
        tbl[3]  = mk(0, 16'h0000, 16'h0000, 0, 16'h0000, 16'h0000, 1, 16'h2, 32'h33333333, 1,  1, 1, 32'h0,        0, 16'h0000);
        // data write/read, wrap-around, fetch wrap
        tbl[4]  = mk(0, 16'h0001, 16'h0000, 1, 16'h0005, 16'hBEEF, 0, 16'h0, 32'h0,        0,  0, 1, 32'h22222222, 0, 16'h0000);
        tbl[5]  = mk(0, 16'h0000, 16'h0005, 0, 16'h0000, 16'h0000, 0, 16'h0, 32'h0,        0,  0, 1, 32'h11111111, 1, 16'hBEEF);
        tbl[6]  = mk(0, 16'h0100, 16'h0005, 1, 16'h0103, 16'h1234, 0, 16'h0, 32'h0,        0,  0, 1, 32'h11111111, 1, 16'hBEEF);
        tbl[7]  = mk(0, 16'h0002, 16'h0003, 0, 16'h0000, 16'h0000, 0, 16'h0, 32'h0,        0,  0, 1, 32'h33333333, 1, 16'h1234);
        // same-edge collision on dmem[7]
        tbl[8]  = mk(0, 16'h0002, 16'h0003, 1, 16'h0007, 16'hAAAA, 0, 16'h0, 32'h0,        0,  0, 1, 32'h33333333, 1, 16'h1234);
        tbl[9]  = mk(0, 16'h0002, 16'h0007, 1, 16'h0007, 16'h5555, 0, 16'h0, 32'h0,        0,  0, 1, 32'h33333333, 1, COL_EXP);
        tbl[10] = mk(0, 16'h0002, 16'h0007, 0, 16'h0000, 16'h0000, 0, 16'h0, 32'h0,        0,  0, 1, 32'h33333333, 1, 16'h5555);
        // ld_* ignored in RUN (imem[0] must keep 0x11111111)
        tbl[11] = mk(0, 16'h0000, 16'h0007, 0, 16'h0000, 16'h0000, 1, 16'h0, 32'hDEADBEEF, 1,  0, 1, 32'h11111111, 1, 16'h5555);
        tbl[12] = mk(0, 16'h0000, 16'h0007, 1, 16'h0009, 16'h0909, 0, 16'h0, 32'h0,        0,  0, 1, 32'h11111111, 1, 16'h5555);
        // reset mid-run with a write to 9 and a load beat: both dropped
        tbl[13] = mk(1, 16'h0000, 16'h0009, 1, 16'h0009, 16'hFFFF, 1, 16'h1, 32'hCAFECAFE, 1,  0, 0, 32'h0,        1, 16'h0000);
        // LOAD: dmem readable, mem_wen ignored
        tbl[14] = mk(0, 16'h0000, 16'h0009, 1, 16'h0009, 16'h7777, 0, 16'h0, 32'h0,        0,  1, 0, 32'h0,        1, 16'h0909);
        tbl[15] = mk(0, 16'h0000, 16'h0009, 0, 16'h0000, 16'h0000, 0, 16'h0, 32'h0,        0,  1, 0, 32'h0,        1, 16'h0909);
        tbl[16] = mk(0, 16'h0000, 16'h0009, 0, 16'h0000, 16'h0000, 1, 16'h3, 32'h44444444, 1,  1, 1, 32'h0,        1, 16'h0909);
        tbl[17] = mk(0, 16'h0003, 16'h0009, 0, 16'h0000, 16'h0000, 0, 16'h0, 32'h0,        0,  0, 1, 32'h44444444, 1, 16'h0909);
        tbl[18] = mk(0, 16'h0001, 16'h0105, 0, 16'h0000, 16'h0000, 0, 16'h0, 32'h0,        0,  0, 1, 32'h22222222, 1, 16'hBEEF);
        // backpressure: valid 1,0,1 with ld_last also on the idle beat
        tbl[19] = mk(1, 16'h0000, 16'h0005, 0, 16'h0000, 16'h0000, 0, 16'h0, 32'h0,        0,  0, 0, 32'h0,        1, 16'h0000);
        tbl[20] = mk(0, 16'h0000, 16'h0005, 0, 16'h0000, 16'h0000, 1, 16'h5, 32'h55555555, 0,  1, 0, 32'h0,        1, 16'hBEEF);
        tbl[21] = mk(0, 16'h0000, 16'h0005, 0, 16'h0000, 16'h0000, 0, 16'h0, 32'hBAD0BAD0, 1,  1, 0, 32'h0,        1, 16'hBEEF);
        tbl[22] = mk(0, 16'h0000, 16'h0005, 0, 16'h0000, 16'h0000, 1, 16'h6, 32'h66666666, 1,  1, 1, 32'h0,        1, 16'hBEEF);
        tbl[23] = mk(0, 16'h0000, 16'h0005, 0, 16'h0000, 16'h0000, 0, 16'h0, 32'h0,        0,  0, 1, 32'h11111111, 1, 16'hBEEF);
        tbl[24] = mk(0, 16'h0005, 16'h0005, 0, 16'h0000, 16'h0000, 0, 16'h0, 32'h0,        0,  0, 1, 32'h55555555, 1, 16'hBEEF);
        tbl[25] = mk(0, 16'h0006, 16'h0005, 0, 16'h0000, 16'h0000, 0, 16'h0, 32'h0,        0,  0, 1, 32'h66666666, 1, 16'hBEEF);
        tbl[26] = mk(0, 16'h0105, 16'h0005, 0, 16'h0000, 16'h0000, 0, 16'h0, 32'h0,        0,  0, 1, 32'h55555555, 1, 16'hBEEF);

        foreach (tbl[i]) begin
            apply(tbl[i]);
        end

        // Streamed load of 8 consecutive words, then fetch each back.
        apply(mk(1, 16'h0, 16'h0, 0, 16'h0, 16'h0, 0, 16'h0, 32'h0, 0, 0, 0, 32'h0, 1, 16'h0));
        for (int i = 0; i < 8; i++) begin
            a = 16'h0020 + 16'(i);
            d = 32'hA5000000 | 32'(i * 32'h00010101);
            apply(mk(0, 16'h0, 16'h0, 0, 16'h0, 16'h0, 1, a, d, (i == 7), 1, (i == 7), 32'h0, 0, 16'h0));
        end
        for (int i = 0; i < 8; i++) begin
            a = 16'h0020 + 16'(i);
            d = 32'hA5000000 | 32'(i * 32'h00010101);
            apply(mk(0, a, 16'h0, 0, 16'h0, 16'h0, 0, 16'h0, 32'h0, 0, 0, 1, d, 0, 16'h0));
        end

        // Reset in the middle of a load: the beat on the reset cycle is dropped.
        apply(mk(1, 16'h0, 16'h0, 0, 16'h0, 16'h0, 0, 16'h0, 32'h0, 0, 0, 0, 32'h0, 1, 16'h0));
        apply(mk(0, 16'h0, 16'h0, 0, 16'h0, 16'h0, 1, 16'h0030, 32'h12345678, 0, 1, 0, 32'h0, 0, 16'h0));
        apply(mk(1, 16'h0, 16'h0, 0, 16'h0, 16'h0, 1, 16'h0030, 32'h87654321, 1, 0, 0, 32'h0, 1, 16'h0));
        apply(mk(0, 16'h0, 16'h0, 0, 16'h0, 16'h0, 1, 16'h0031, 32'h0BADF00D, 1, 1, 1, 32'h0, 0, 16'h0));
        apply(mk(0, 16'h0030, 16'h0, 0, 16'h0, 16'h0, 0, 16'h0, 32'h0, 0, 0, 1, 32'h12345678, 0, 16'h0));
        apply(mk(0, 16'h0031, 16'h0, 0, 16'h0, 16'h0, 0, 16'h0, 32'h0, 0, 0, 1, 32'h0BADF00D, 0, 16'h0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/mem_server.md
# mem_server

Responder for the processor core's fetch and data-memory ports. It owns the instruction RAM and the data RAM. Every `pc` and `readmem0` request is answered with a registered read one cycle later, and `mem_wen` writes are committed. After reset it runs a loader state machine: the host streams the program into instruction RAM over a valid/ready handshake, and the core is held idle until the final word has been accepted.

## Interface
- `IMEM_DEPTH`, default 256: instruction RAM depth in 32-bit words. Must be a power of two.
- `DMEM_DEPTH`, default 256: data RAM depth in 16-bit words. Must be a power of two.

Ports:
- `clk`  in  1  single clock; all logic is on its rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `pc`  in  16  instruction fetch address, from the core.
- `instr`  out  32  fetched instruction word.
- `readmem0`  in  16  data read address.
- `in_mem0`  out  16  data read result.
- `mem_wen`  in  1  data write enable.
- `mem_waddr`  in  16  data write address.
- `mem_wval`  in  16  data write value.
- `ld_valid`  in  1  host load word valid.
- `ld_ready`  out  1  server can accept a load word.
- `ld_addr`  in  16  instruction RAM address of the load word.
- `ld_data`  in  32  load word.
- `ld_last`  in  1  marks the final load word.
- `core_run`  out  1  high once the program is loaded; gates the core's clock enable at the top level.

## Operation
- **States:** `LOAD`, `RUN`. Reset enters `LOAD`.
- **`LOAD`:**
  - `ld_ready`=1, `core_run`=0.
  - A transfer occurs on any cycle with `ld_valid`&&`ld_ready`. It writes `imem[ld_addr mod IMEM_DEPTH]` = `ld_data`.
  - A transfer with `ld_last`=1 moves to `RUN` on the next edge.
  - `ld_valid` without `ld_ready` is a no-op.
  - `mem_wen` is ignored. `instr` is driven to 0.
  - `in_mem0` continues to track data reads, so the host can inspect data RAM.
- **`RUN`:**
  - `ld_ready`=0, `core_run`=1. `ld_*` are ignored.
  - Fetch: `instr` <= `imem[pc mod IMEM_DEPTH]` every cycle.
  - Data read: `in_mem0` <= `dmem[readmem0 mod DMEM_DEPTH]` every cycle.
  - Data write: if `mem_wen`, `dmem[mem_waddr mod DMEM_DEPTH]` <= `mem_wval`.
- **Addressing:** only the low log2(DEPTH) address bits are used. Upper bits are discarded silently, so out-of-range addresses wrap and never fault.
- **Arithmetic:** none beyond truncation. Widths are exact and there is no sign extension.
- **Reset:**
  - Any cycle with `rst`=1, including mid-load or mid-run, returns to `LOAD`.
  - RAM contents are preserved; reset never clears RAM.
  - Reset outputs: `instr`=0, `in_mem0`=0, `ld_ready`=0 (during the reset cycle), `core_run`=0.
- **Reset priority:** `rst` overrides everything in the same cycle. A transfer or write presented on the reset cycle is dropped.

## Timing
- Read latency is exactly 1 cycle on both ports. An address sampled at edge N appears on the output after edge N; it is valid for sampling at edge N+1.
- The core holds `pc`/`readmem0` stable for at least 2 cycles, so there is no request handshake on core ports.
- Writes take effect at the edge where `mem_wen`=1. A read of that address sampled at a later edge returns the new value.
- **Same-edge read/write to the same address:** behaviour is set by Configuration.
- **Load throughput:** one word per cycle while `ld_valid` is held. `ld_ready` does not drop between words.
- **Handover:** the edge that accepts `ld_last` is edge N.
  - `ld_ready` falls and `core_run` rises after N.
  - The first fetch at the core's `pc` is sampled at N+1; `instr` is valid after N+1.
- `ld_ready` rises on the first cycle after `rst` deasserts.

## Configuration
- `MEM_SERVER_BYPASS_EN` defined: write-to-read forwarding.
  - If `mem_wen` && (`mem_waddr` mod D) == (`readmem0` mod D) at the same edge, `in_mem0` <= `mem_wval`.
  - This applies only in `RUN`.
- Undefined: read-before-write. `in_mem0` returns the old RAM contents for that edge.

## Test plan
- **Load then fetch:** rst 1 cycle; load words 0x11111111@0, 0x22222222@1, 0x33333333@2 (last) on consecutive cycles.
  - `ld_ready`=1 throughout the load.
  - `core_run` rises the cycle after the third word.
  - `pc`=1 gives `instr`=0x22222222 one cycle later.
- **Backpressure/idle in `LOAD`:** `ld_valid` toggles 1,0,1 with `ld_last` on the final word.
  - Exactly 2 writes occur; `RUN` is entered only after the `ld_last` beat.
  - `instr` stays 0 during `LOAD`.
- **Data write/read:** in `RUN`, write 0xBEEF@0x0005; read 0x0005 the next cycle.
  - `in_mem0`=0xBEEF.
  - A `mem_wen` pulse during `LOAD` leaves `dmem` unchanged.
- **Wrap-around** (`DMEM_DEPTH`=256): write 0x1234@0x0103, then read 0x0003.
  - Returns 0x1234.
  - Fetch `pc`=0x0100 returns `imem[0]`.
- **Same-edge collision:** `dmem[7]`=0xAAAA; at one edge, write 0x5555@7 and read 7.
  - With `MEM_SERVER_BYPASS_EN`: `in_mem0`=0x5555.
  - Without: 0xAAAA, then 0x5555 on the next read.
- **Reset mid-run:** assert `rst` during `RUN` while `mem_wen`=1 to addr 9.
  - `core_run`=0, `instr`=0, `in_mem0`=0 after the edge.
  - `dmem[9]` is unchanged.
  - Prior `imem`/`dmem` contents survive; a reload of a single `ld_last` word returns to `RUN`.
